// File: rtl/tinyalu_pkg.sv
// tinyALU shared definitions: opcode and dispatcher state encodings, plus
// default multiplier timing constants used by tinyalu_dispatch.
// Contents: op_e, state_e, MUL_MIN_LAT_DEF, MUL_TIMEOUT_DEF.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    // Edges after MUL launch during which a multiplier done is treated as stale.
    localparam int MUL_MIN_LAT_DEF = 3;
    // Edges after MUL launch at which an unanswered MUL is aborted.
    localparam int MUL_TIMEOUT_DEF = 16;

endpackage

// File: rtl/tinyalu_dispatch.sv
// tinyALU operation dispatcher: ADD/AND/XOR in one cycle, MUL handed to the
// external three-cycle multiplier with stale-done filtering and a timeout.
// Ports: command in (start, op, A, B), completion out (done, result, err, busy),
// multiplier side (mult_start/mult_a/mult_b out, mult_done/mult_result in).
module tinyalu_dispatch
    import tinyalu_pkg::*;
#(
    parameter int MUL_MIN_LAT = MUL_MIN_LAT_DEF,
    parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        done,
    output logic [15:0] result,
    output logic        err,
    output logic        busy,
    output logic        mult_start,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic        mult_done,
    input  logic [15:0] mult_result
);

    // One spare bit above what MUL_TIMEOUT needs so saturation never aliases
    // back into the acceptance window.
    localparam int CW = $clog2(MUL_TIMEOUT) + 1;
    localparam logic [CW-1:0] MIN_LAT_C = CW'(MUL_MIN_LAT);
    localparam logic [CW-1:0] TO_LAST_C = CW'(MUL_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_e        state;
    logic [CW-1:0] wait_cnt;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && op != OP_NOP) begin
                        case (op)
                            OP_ADD: begin
                                // Keep the carry: 9-bit sum zero-extended.
                                result <= {7'b0, {1'b0, A} + {1'b0, B}};
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_AND: begin
                                result <= {8'b0, A & B};
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_XOR: begin
                                result <= {8'b0, A ^ B};
                                err    <= 1'b0;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_MUL: begin
                                mult_a     <= A;
                                mult_b     <= B;
                                mult_start <= 1'b1;
                                wait_cnt   <= '0;
                                state      <= ST_MUL_WAIT;
                            end
                            default: begin
                                // Reserved opcodes complete immediately with err.
                                result <= '0;
                                err    <= 1'b1;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end
                end

                ST_MUL_WAIT: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    // A done arriving too soon belongs to a previous launch.
                    // An accepted done beats the timeout on the same edge.
                    if (mult_done && wait_cnt >= MIN_LAT_C) begin
                        result     <= mult_result;
                        err        <= 1'b0;
                        mult_start <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end else if (wait_cnt >= TO_LAST_C) begin
                        result     <= '0;
                        err        <= 1'b1;
                        mult_start <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_dispatch.sv
module tb_tinyalu_dispatch;

    localparam int MIN_LAT = 3;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        mult_start;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_done;
    logic [15:0] mult_result;

    int compared = 0;
    int mismatched = 0;

    // Multiplier source select: behavioural three-cycle multiplier or
    // hand-driven pulses.
    bit          use_model = 1'b1;
    logic        man_done = 1'b0;
    logic [15:0] man_res = 16'h0;
    logic        mdl_done = 1'b0;
    logic [15:0] mdl_res = 16'h0;
    logic        ms_prev = 1'b0;
    int          mcnt = 0;
    logic [15:0] mprod = 16'h0;

    assign mult_done   = use_model ? mdl_done : man_done;
    assign mult_result = use_model ? mdl_res  : man_res;

    always #5 clk = ~clk;

    // Three-cycle multiplier: samples operands on a rising mult_start,
    // raises done for one cycle three edges later.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        ms_prev  <= mult_start;
        if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mdl_done <= 1'b1;
                mdl_res  <= mprod;
            end
        end else if (mult_start && !ms_prev) begin
            mprod <= {8'h00, mult_a} * {8'h00, mult_b};
            mcnt  <= 3;
        end
    end

    tinyalu_dispatch #(.MUL_MIN_LAT(MIN_LAT), .MUL_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .done        (done),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .mult_start  (mult_start),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_done   (mult_done),
        .mult_result (mult_result)
    );

    // Reference: number of negedges after the start edge at which done is
    // seen (0 = cycle right after the start edge), with result and err.
    function automatic void ref_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                    input bit model_on, input int p1, input logic [15:0] v1,
                                    input int p2, input logic [15:0] v2,
                                    output int j, output logic [15:0] r, output logic e);
        int sum;
        j = 0; r = 16'h0; e = 1'b0;
        case (o)
            3'd1: begin sum = int'(a) + int'(b); r = sum[15:0]; end
            3'd2: r = {8'h00, a & b};
            3'd3: r = {8'h00, a ^ b};
            3'd4: begin
                if (model_on) begin
                    // launch edge, sample edge, three multiplier edges, accept edge
                    j = 5;
                    sum = int'(a) * int'(b);
                    r = sum[15:0];
                end else begin
                    // pulse driven after negedge p is seen when p edges have passed
                    if (p1 >= MIN_LAT && p1 <= TIMEOUT - 1) begin
                        j = p1 + 1; r = v1;
                    end else if (p2 >= MIN_LAT && p2 <= TIMEOUT - 1) begin
                        j = p2 + 1; r = v2;
                    end else begin
                        j = TIMEOUT; r = 16'h0; e = 1'b1;
                    end
                end
            end
            default: begin r = 16'h0; e = 1'b1; end
        endcase
    endfunction

    task automatic run_cmd(input string name, input logic [2:0] o, input logic [7:0] a,
                           input logic [7:0] b, input bit model_on,
                           input int p1, input logic [15:0] v1,
                           input int p2, input logic [15:0] v2);
        int          exp_j;
        logic [15:0] exp_r;
        logic        exp_e;
        ref_cmd(o, a, b, model_on, p1, v1, p2, v2, exp_j, exp_r, exp_e);
        use_model = model_on;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b; man_done = 1'b0;
        @(posedge clk);
        for (int j = 0; j <= exp_j; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j < exp_j) begin
                compared++;
                if (done !== 1'b0 || busy !== 1'b1 || mult_start !== 1'b1 ||
                    mult_a !== a || mult_b !== b) begin
                    mismatched++;
                    $display("FAIL %s wait j=%0d: done=%b busy=%b mult_start=%b mult_a=%h mult_b=%h required done=0 busy=1 mult_start=1 mult_a=%h mult_b=%h",
                             name, j, done, busy, mult_start, mult_a, mult_b, a, b);
                end
                man_done = (j == p1) || (j == p2);
                man_res  = (j == p1) ? v1 : v2;
            end else begin
                man_done = 1'b0;
                compared++;
                if (done !== 1'b1 || result !== exp_r || err !== exp_e ||
                    busy !== 1'b1 || mult_start !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s done j=%0d: done=%b result=%h err=%b busy=%b mult_start=%b required done=1 result=%h err=%b busy=1 mult_start=0",
                             name, j, done, result, err, busy, mult_start, exp_r, exp_e);
                end
            end
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
            mismatched++;
            $display("FAIL %s after: done=%b busy=%b result=%h required done=0 busy=0 result=%h",
                     name, done, busy, result, exp_r);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || mult_start !== 1'b0 ||
            result !== 16'h0 || mult_a !== 8'h0 || mult_b !== 8'h0) begin
            mismatched++;
            $display("FAIL reset: done=%b err=%b busy=%b mult_start=%b result=%h mult_a=%h mult_b=%h required all zero",
                     done, err, busy, mult_start, result, mult_a, mult_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [2:0] ops [6];
        ops = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        run_cmd("add_carry", 3'd1, 8'hFF, 8'h01, 1'b1, -1, 16'h0, -1, 16'h0);
        run_cmd("xor", 3'd3, 8'hF0, 8'h3C, 1'b1, -1, 16'h0, -1, 16'h0);
        run_cmd("reserved_110", 3'd6, 8'h12, 8'h34, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int i = 0; i < 20; i++) begin
            run_cmd("alu_rand", ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom),
                    1'b1, -1, 16'h0, -1, 16'h0);
        end
    endtask

    task automatic test_nop();
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 8'h55; B = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL nop cycle %0d: done=%b busy=%b required done=0 busy=0", i, done, busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_mul_model();
        run_cmd("mul_ff_ff", 3'd4, 8'hFF, 8'hFF, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int i = 0; i < 6; i++) begin
            run_cmd("mul_rand", 3'd4, 8'($urandom), 8'($urandom), 1'b1, -1, 16'h0, -1, 16'h0);
        end
    endtask

    task automatic test_mul_manual();
        int p1;
        int p2;
        run_cmd("stale_then_real", 3'd4, 8'd2, 8'd3, 1'b0, 1, 16'h1234, 4, 16'h0006);
        run_cmd("timeout", 3'd4, 8'h11, 8'h22, 1'b0, -1, 16'h0, -1, 16'h0);
        run_cmd("stale_only_cnt2", 3'd4, 8'h01, 8'h01, 1'b0, 2, 16'hBEEF, -1, 16'h0);
        run_cmd("done_at_timeout_edge", 3'd4, 8'h03, 8'h04, 1'b0, 15, 16'h00C3, -1, 16'h0);
        run_cmd("done_at_min_lat", 3'd4, 8'h05, 8'h06, 1'b0, 3, 16'h0A5A, -1, 16'h0);
        for (int i = 0; i < 8; i++) begin
            p1 = $urandom_range(0, 6);
            p2 = $urandom_range(p1 + 1, 20);
            run_cmd("mul_manual_rand", 3'd4, 8'($urandom), 8'($urandom), 1'b0,
                    p1, 16'($urandom), p2, 16'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_r;
        a = 8'($urandom); b = 8'($urandom);
        exp_r = {8'h00, a} + {8'h00, b};
        use_model = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = a; B = b;
        @(posedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            compared++;
            if (done !== (j % 2 == 0) || (done === 1'b1 && result !== exp_r)) begin
                mismatched++;
                $display("FAIL back_to_back j=%0d: done=%b result=%h required done=%0d result=%h",
                         j, done, result, (j % 2 == 0), exp_r);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        use_model = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 8'd5; B = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || mult_start !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_mid_mul: busy=%b mult_start=%b done=%b result=%h required all zero",
                     busy, mult_start, done, result);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_mid_mul late %0d: done=%b busy=%b required done=0 busy=0", i, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_nop();
        test_mul_model();
        test_mul_manual();
        test_back_to_back();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
